// File: rtl/bram_test_sequencer.sv
// Block RAM self-test sequencer: write pass of P(a)=SEED^a, then read/compare pass under a timeout timer.
// Optional first-mismatch capture (err_addr_o/err_data_o) when BRAM_TEST_ERR_CAPTURE_EN is defined.
module bram_test_sequencer #(
    parameter int          ADDR_WIDTH   = 10,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] SEED         = 32'hA5A5_0001,
    parameter int          READ_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic                  timer_reset_o,
    input  logic                  timed_out_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [15:0]           err_count_o
`ifdef BRAM_TEST_ERR_CAPTURE_EN
    ,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic [DATA_WIDTH-1:0] err_data_o
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [DATA_WIDTH-1:0] SEED_W     = DATA_WIDTH'(SEED);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [2:0]            DRAIN_LAST = 3'(READ_LATENCY);

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
        return SEED_W ^ DATA_WIDTH'(a);
    endfunction

    state_t                                   r_state;
    logic                                     r_we, r_timer_rst, r_busy, r_done, r_pass, r_timeout;
    logic [ADDR_WIDTH-1:0]                    r_addr;
    logic [DATA_WIDTH-1:0]                    r_wdata;
    logic [15:0]                              r_err_count;
    logic [2:0]                               r_drain;
    logic [READ_LATENCY-1:0]                  r_pipe_vld;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0]  r_pipe_exp;
`ifdef BRAM_TEST_ERR_CAPTURE_EN
    logic [READ_LATENCY-1:0][ADDR_WIDTH-1:0]  r_pipe_addr;
    logic [ADDR_WIDTH-1:0]                    r_err_addr;
    logic [DATA_WIDTH-1:0]                    r_err_data;
`endif

    logic w_abort, w_mismatch;
    assign w_abort    = r_busy && timed_out_i;
    assign w_mismatch = r_pipe_vld[READ_LATENCY-1] && (ram_rdata_i != r_pipe_exp[READ_LATENCY-1]);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_timer_rst <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_count <= '0;
            r_drain     <= '0;
            r_pipe_vld  <= '0;
            r_pipe_exp  <= '0;
`ifdef BRAM_TEST_ERR_CAPTURE_EN
            r_pipe_addr <= '0;
            r_err_addr  <= '0;
            r_err_data  <= '0;
`endif
        end else begin
            // Stage 0 captures the address presented during the cycle just ending.
            r_pipe_vld[0] <= (r_state == S_READ) && !w_abort;
            r_pipe_exp[0] <= pat(r_addr);
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1] && !w_abort;
                r_pipe_exp[i] <= r_pipe_exp[i-1];
            end
`ifdef BRAM_TEST_ERR_CAPTURE_EN
            r_pipe_addr[0] <= r_addr;
            for (int i = 1; i < READ_LATENCY; i++)
                r_pipe_addr[i] <= r_pipe_addr[i-1];
`endif
            if (w_mismatch && !w_abort) begin
                if (r_err_count != 16'hFFFF)
                    r_err_count <= r_err_count + 16'd1;
`ifdef BRAM_TEST_ERR_CAPTURE_EN
                if (r_err_count == 16'd0) begin
                    r_err_addr <= r_pipe_addr[READ_LATENCY-1];
                    r_err_data <= ram_rdata_i;
                end
`endif
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_state     <= S_WRITE;
                        r_addr      <= '0;
                        r_wdata     <= pat('0);
                        r_we        <= 1'b1;
                        r_timer_rst <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_err_count <= '0;
`ifdef BRAM_TEST_ERR_CAPTURE_EN
                        r_err_addr  <= '0;
                        r_err_data  <= '0;
`endif
                    end
                end
                S_WRITE: begin
                    if (r_addr == ADDR_LAST) begin
                        r_state <= S_READ;
                        r_addr  <= '0;
                        r_we    <= 1'b0;
                    end else begin
                        r_addr  <= r_addr + ADDR_ONE;
                        r_wdata <= pat(r_addr + ADDR_ONE);
                    end
                end
                S_READ: begin
                    if (r_addr == ADDR_LAST) begin
                        r_state <= S_DRAIN;
                        r_drain <= '0;
                    end else begin
                        r_addr  <= r_addr + ADDR_ONE;
                    end
                end
                S_DRAIN: begin
                    // The last compare lands on the edge before this one, so err_count is final here.
                    if (r_drain == DRAIN_LAST) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_timer_rst <= 1'b1;
                        r_pass      <= (r_err_count == 16'd0);
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_abort) begin
                r_state     <= S_DONE;
                r_we        <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_timer_rst <= 1'b1;
                r_timeout   <= 1'b1;
                r_pass      <= 1'b0;
            end
        end
    end

    assign ram_we_o      = r_we;
    assign ram_addr_o    = r_addr;
    assign ram_wdata_o   = r_wdata;
    assign timer_reset_o = r_timer_rst;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign pass_o        = r_pass;
    assign timeout_o     = r_timeout;
    assign err_count_o   = r_err_count;
`ifdef BRAM_TEST_ERR_CAPTURE_EN
    assign err_addr_o    = r_err_addr;
    assign err_data_o    = r_err_data;
`endif
endmodule

// File: tb/tb_bram_test_sequencer.sv
// Scoreboard bench for bram_test_sequencer (ADDR_WIDTH=4, READ_LATENCY=1) with an ideal RAM model.
module tb_bram_test_sequencer;
    logic        clk_i = 1'b0;
    logic        reset_i, start_i, timed_out_i;
    logic        ram_we_o, timer_reset_o, busy_o, done_o, pass_o, timeout_o;
    logic [3:0]  ram_addr_o;
    logic [31:0] ram_wdata_o, ram_rdata_i;
    logic [15:0] err_count_o;
`ifdef BRAM_TEST_ERR_CAPTURE_EN
    logic [3:0]  err_addr_o;
    logic [31:0] err_data_o;
`endif

    typedef struct {
        int          lat;
        logic [15:0] err;
        logic        pass;
        logic        tmo;
        logic [3:0]  eaddr;
        logic [31:0] edata;
    } res_t;

    logic [35:0] wq[$];
    res_t        rq[$];
    logic [31:0] mem [16];
    logic        fault = 1'b0;
    int          cnt = 0;
    int          n_chk = 0;
    int          n_bad = 0;

    bram_test_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .SEED(32'hA5A5_0001), .READ_LATENCY(1)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
        .timer_reset_o(timer_reset_o), .timed_out_i(timed_out_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o), .err_count_o(err_count_o)
`ifdef BRAM_TEST_ERR_CAPTURE_EN
        , .err_addr_o(err_addr_o), .err_data_o(err_data_o)
`endif
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cnt <= cnt + 1;

    // Ideal one-cycle RAM; the fault flips bit 0 on reads of address 5.
    always @(posedge clk_i) begin
        if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
        ram_rdata_i <= mem[ram_addr_o] ^ {31'b0, (fault && ram_addr_o == 4'd5)};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (ram_we_o === 1'b1) begin
            if (wq.size() == 0) chk("wr_extra", {28'b0, ram_addr_o, ram_wdata_o}, 64'hDEAD);
            else chk("wr", {28'b0, ram_addr_o, ram_wdata_o}, {28'b0, wq.pop_front()});
        end
    end

    task automatic chk_idle(input string pfx);
        chk({pfx, "_we"},    ram_we_o, 0);
        chk({pfx, "_timer"}, timer_reset_o, 1);
        chk({pfx, "_busy"},  busy_o, 0);
        chk({pfx, "_done"},  done_o, 0);
        chk({pfx, "_pass"},  pass_o, 0);
        chk({pfx, "_tmo"},   timeout_o, 0);
        chk({pfx, "_err"},   err_count_o, 0);
        chk({pfx, "_addr"},  ram_addr_o, 0);
        chk({pfx, "_wdata"}, ram_wdata_o, 0);
    endtask

    // to_at/st_at/rst_at: run cycle at which timeout/start/reset is sampled (0 = none).
    task automatic run(input int to_at, input int st_at, input int rst_at, input logic [15:0] e_err);
        res_t r, g;
        int   nw, t0;
        bit   got_done;
        nw = (to_at > 0) ? to_at : ((rst_at > 0) ? rst_at : 16);
        for (int a = 0; a < nw; a++) wq.push_back({4'(a), 32'hA5A50001 ^ 32'(a)});
        if (rst_at == 0) begin
            r.lat   = (to_at > 0) ? to_at : 2 * 16 + 1 + 1;
            r.err   = e_err;
            r.pass  = (e_err == 0) && (to_at == 0);
            r.tmo   = (to_at > 0);
            r.eaddr = (e_err != 0) ? 4'd5 : 4'd0;
            r.edata = (e_err != 0) ? 32'hA5A50005 : 32'd0;
            rq.push_back(r);
        end
        @(negedge clk_i) start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        t0 = cnt;
        got_done = 1'b0;
        for (int k = 0; k < 80 && !got_done; k++) begin
            @(negedge clk_i);
            if (rst_at > 0 && cnt - t0 == rst_at) begin
                reset_i = 1'b0;
                chk_idle("rst");
                chk("rst_wq_left", wq.size(), 0);
                wq.delete();
                return;
            end
            if (done_o) begin
                got_done = 1'b1;
            end else begin
                if (cnt - t0 == 5) begin
                    chk("run_timer", timer_reset_o, 0);
                    chk("run_busy", busy_o, 1);
                end
                timed_out_i = (to_at > 0 && cnt - t0 == to_at - 1);
                start_i     = (st_at > 0 && cnt - t0 == st_at - 1);
                reset_i     = (rst_at > 0 && cnt - t0 == rst_at - 1);
            end
        end
        timed_out_i = 1'b0;
        start_i = 1'b0;
        if (!got_done) begin
            chk("done_wait", 0, 1);
            return;
        end
        g = rq.pop_front();
        chk("latency", cnt - t0, g.lat);
        chk("err_count", err_count_o, g.err);
        chk("pass", pass_o, g.pass);
        chk("timeout", timeout_o, g.tmo);
        chk("done_busy", busy_o, 0);
        chk("done_timer", timer_reset_o, 1);
        chk("done_we", ram_we_o, 0);
`ifdef BRAM_TEST_ERR_CAPTURE_EN
        chk("err_addr", err_addr_o, g.eaddr);
        chk("err_data", err_data_o, g.edata);
`endif
        // A few idle cycles in DONE must produce no writes and hold the result.
        repeat (3) @(negedge clk_i);
        chk("hold_done", done_o, 1);
        chk("hold_err", err_count_o, g.err);
        chk("wq_left", wq.size(), 0);
        wq.delete();
    endtask

    initial begin
        reset_i = 1'b1;
        start_i = 1'b0;
        timed_out_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_idle("reset");
        reset_i = 1'b0;
        repeat (2) @(negedge clk_i);

        run(0, 0, 0, 16'd0);      // clean run
        fault = 1'b1;
        run(0, 0, 0, 16'd1);      // single-bit fault at address 5
        fault = 1'b0;
        run(0, 0, 0, 16'd0);      // restart from DONE, clean RAM
        run(10, 0, 0, 16'd0);     // timeout mid-write
        run(0, 20, 0, 16'd0);     // start while busy is ignored
        run(0, 0, 12, 16'd0);     // reset mid-run
        run(0, 0, 0, 16'd0);      // recovers after reset

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
